pwm_decoder: RTL and testbench

//  Measures the high-time of an RC/servo PWM input (1-2 ms typ., 20 ms frame) in whole microseconds.

---
 rtl/pwm_decoder.sv | 120 ++++++++++++
 tb/tb_pwm_decoder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - RC/servo PWM high-time decoder reporting whole microseconds or error codes.
// Optional PWMDEC_GLITCH_FILTER_EN: input level changes only after 3 equal synchronized samples.
module pwm_decoder #(
  parameter int clockFreq = 50_000_000,
  parameter int MIN_US    = 800,
  parameter int MAX_US    = 2500,
  parameter int LOSS_US   = 25000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pwm,
  output logic        o_pwm_ready,
  output logic [15:0] o_pwm_value
);

  localparam int CLKS_PER_US = clockFreq / 1_000_000;
  localparam int PW          = $clog2(CLKS_PER_US);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_US - 1);
  localparam logic [15:0] MIN_V      = 16'(MIN_US);
  localparam logic [15:0] MAX_V      = 16'(MAX_US);
  localparam logic [15:0] TOO_LONG_V = 16'(MAX_US + 1);
  localparam logic [15:0] LOSS_V     = 16'(LOSS_US);
  localparam logic [15:0] ERR_LONG   = 16'h8000;
  localparam logic [15:0] ERR_SHORT  = 16'h8001;
  localparam logic [15:0] ERR_LOSS   = 16'h8002;

  typedef enum logic [1:0] {WAIT_LOW, IDLE, HIGH, ERR_HIGH} state_t;

  state_t          state_q;
  logic            pwm_meta_q, pwm_sync_q, lvl, lvl_prev_q;
  logic            rise, fall, any_edge, wrap, loss_hit;
  logic [PW-1:0]   presc_q, presc_d;
  logic [15:0]     us_q, us_d, us_next, loss_q, loss_d;
  logic            ready_q;
  logic [15:0]     value_q;

  // Synchronizer and edge history are left unreset so a pulse in flight
  // across reset is still seen as high and skipped by WAIT_LOW.
  always_ff @(posedge i_clk) begin
    pwm_meta_q <= i_pwm;
    pwm_sync_q <= pwm_meta_q;
  end

`ifdef PWMDEC_GLITCH_FILTER_EN
  logic [1:0] hist_q;
  logic       lvl_q;
  always_ff @(posedge i_clk) begin
    hist_q <= {hist_q[0], pwm_sync_q};
    if (pwm_sync_q == hist_q[0] && hist_q[0] == hist_q[1]) lvl_q <= pwm_sync_q;
  end
  assign lvl = lvl_q;
`else
  assign lvl = pwm_sync_q;
`endif

  always_ff @(posedge i_clk) lvl_prev_q <= lvl;

  assign rise     = lvl & ~lvl_prev_q;
  assign fall     = ~lvl & lvl_prev_q;
  assign any_edge = rise | fall;
  assign wrap     = (presc_q == PRESC_LAST);
  assign loss_hit = wrap && (loss_q >= LOSS_V - 16'd1);

  // us_next includes the wrap happening this cycle, giving floor(elapsed us) at the edge.
  always_comb begin
    us_next = us_q;
    if (wrap && us_q != 16'hFFFF) us_next = us_q + 16'd1;
    presc_d = (any_edge || wrap) ? '0 : presc_q + PW'(1);
    us_d    = rise ? 16'd0 : us_next;
    loss_d  = loss_q;
    if (any_edge || (state_q == IDLE && loss_hit)) loss_d = 16'd0;
    else if (wrap && loss_q != LOSS_V)             loss_d = loss_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= WAIT_LOW;
      presc_q <= '0;
      us_q    <= 16'd0;
      loss_q  <= 16'd0;
      ready_q <= 1'b0;
      value_q <= 16'd0;
    end else begin
      presc_q <= presc_d;
      us_q    <= us_d;
      loss_q  <= loss_d;
      ready_q <= 1'b0;
      case (state_q)
        WAIT_LOW: if (!lvl) state_q <= IDLE;
        IDLE: begin
          if (rise) begin
            state_q <= HIGH;
          end else if (loss_hit) begin
            ready_q <= 1'b1;
            value_q <= ERR_LOSS;
          end
        end
        HIGH: begin
          if (fall) begin
            ready_q <= 1'b1;
            state_q <= IDLE;
            if (us_next < MIN_V)       value_q <= ERR_SHORT;
            else if (us_next <= MAX_V) value_q <= us_next;
            else                       value_q <= ERR_LONG;
          end else if (us_next == TOO_LONG_V) begin
            ready_q <= 1'b1;
            value_q <= ERR_LONG;
            state_q <= ERR_HIGH;
          end
        end
        ERR_HIGH: if (fall) state_q <= IDLE;
        default:  state_q <= WAIT_LOW;
      endcase
    end
  end

  assign o_pwm_ready = ready_q;
  assign o_pwm_value = value_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb/tb_pwm_decoder.sv - self-checking bench for pwm_decoder with a timing-scaled clock (2 MHz, 2 clk/us).
module tb_pwm_decoder;

  localparam int CF   = 2_000_000;
  localparam int CPU  = CF / 1_000_000;
  localparam int MIN  = 80;
  localparam int MAX  = 250;
  localparam int LOSS = 600;
`ifdef PWMDEC_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    int val;
    int cyc;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm = 1'b0;
  logic        ready;
  logic [15:0] value;

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;
  int   prev_val = 0;
  ev_t  exp_q[$];

  pwm_decoder #(
    .clockFreq(CF), .MIN_US(MIN), .MAX_US(MAX), .LOSS_US(LOSS)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_pwm(pwm),
    .o_pwm_ready(ready), .o_pwm_value(value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_eq(string tag, int obs, int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at cycle %0d", tag, obs, obs, exp, exp, cyc);
    end
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: width = floor(high clocks / clocks-per-us); events timed from the pin edges.
  task automatic pulse(int hc, int lc);
    int c0, cf, w;
    w = hc / CPU;
    pwm = 1'b1;
    c0 = cyc;
    if (w > MAX) exp_q.push_back('{val: 'h8000, cyc: c0 + (MAX + 1) * CPU});
    tick(hc);
    pwm = 1'b0;
    cf = cyc;
    if (w < MIN)       exp_q.push_back('{val: 'h8001, cyc: cf});
    else if (w <= MAX) exp_q.push_back('{val: w, cyc: cf});
    for (int n = 1; n * LOSS * CPU < lc; n++)
      exp_q.push_back('{val: 'h8002, cyc: cf + n * LOSS * CPU});
    tick(lc);
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if (rst) begin
      prev_val = int'(value);
    end else if (mon_en) begin
      if (ready) begin
        if (exp_q.size() == 0) begin
          expect_eq("spurious_ready", int'(ready), 0);
        end else begin
          e = exp_q.pop_front();
          expect_eq("value", int'(value), e.val);
          expect_eq("latency", cyc - e.cyc, LAT);
        end
      end else if (int'(value) != prev_val) begin
        expect_eq("value_hold", int'(ready), 1);
      end
      prev_val = int'(value);
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    tick(6);
    expect_eq("reset_ready", int'(ready), 0);
    expect_eq("reset_value", int'(value), 0);
    rst = 1'b0;
    mon_en = 1'b1;
    tick(10);

    pulse(100 * CPU, 200 * CPU);
    pulse(150 * CPU, 200 * CPU);
    pulse(200 * CPU, 200 * CPU);
    pulse(MIN * CPU, 200 * CPU);
    pulse(MAX * CPU, 200 * CPU);
    pulse(MIN * CPU - 1, 200 * CPU);
    pulse(MAX * CPU + 1, 200 * CPU);
    pulse(70 * CPU, 200 * CPU);
    pulse((MAX + 1) * CPU, 200 * CPU);
    pulse(300 * CPU, 1300 * CPU);

    for (int i = 0; i < 3; i++) pulse(120 * CPU, 200 * CPU);
    pulse(110 * CPU, 200 * CPU);
    pulse(170 * CPU, 200 * CPU);
    pulse(130 * CPU, 200 * CPU);

    pwm = 1'b1;
    tick(50 * CPU);
    rst = 1'b1;
    tick(5);
    rst = 1'b0;
    expect_eq("mid_reset_value", int'(value), 0);
    expect_eq("mid_reset_ready", int'(ready), 0);
    tick(50 * CPU);
    pwm = 1'b0;
    tick(200 * CPU);
    pulse(150 * CPU, 200 * CPU);

    for (int i = 0; i < 12; i++)
      pulse(int'($urandom_range(60 * CPU, 280 * CPU)), int'($urandom_range(30 * CPU, 500 * CPU)));

    tick(20);
    expect_eq("pending_events", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
